// File: rtl/gate_self_test.sv
// gate_self_test: walks a two-input gate bank through all operand pairs and flags per-gate mismatches.
module gate_self_test #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  output logic       a,
  output logic       b,
  input  logic [6:0] y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [6:0] fail_mask,
  output logic [2:0] fail_count,
  output logic [1:0] first_fail_idx
);
  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;
  localparam logic [7:0] LAST = 8'(SETTLE_CYCLES - 1);
  state_t state, state_n;
  logic [1:0] idx;
  logic [7:0] cnt;
  logic [6:0] expected, mism;
  logic launch;
  assign a = idx[1];
  assign b = idx[0];
  assign expected = {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~a, a | b, a & b};
  assign mism = y ^ expected;
  assign busy = state == SETTLE || state == CHECK;
  assign done = state == DONE;
  assign pass = done && fail_mask == 7'd0;
  assign launch = !abort && start && (state == IDLE || state == DONE);
  always_comb begin
    state_n = state;
    if (abort) state_n = IDLE;
    else if (launch) state_n = SETTLE;
    else if (state == SETTLE && cnt == LAST) state_n = CHECK;
    else if (state == CHECK) state_n = idx == 2'd3 ? DONE : SETTLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      idx            <= 2'd0;
      cnt            <= 8'd0;
      fail_mask      <= 7'd0;
      fail_count     <= 3'd0;
      first_fail_idx <= 2'd0;
    end else begin
      state <= state_n;
      if (abort) begin
        idx <= 2'd0;
        cnt <= 8'd0;
      end else if (launch) begin
        idx            <= 2'd0;
        cnt            <= 8'd0;
        fail_mask      <= 7'd0;
        fail_count     <= 3'd0;
        first_fail_idx <= 2'd0;
      end else if (state == SETTLE) begin
        cnt <= cnt + 8'd1;
      end else if (state == CHECK) begin
        fail_mask <= fail_mask | mism;
        if (mism != 7'd0) begin
          fail_count <= fail_count + 3'd1;
          if (fail_count == 3'd0) first_fail_idx <= idx;
        end
        // idx stays at 3 in DONE so the last operand pair is still applied
        if (idx != 2'd3) begin
          idx <= idx + 2'd1;
          cnt <= 8'd0;
        end
      end
    end
  end
endmodule
